// File: rtl/avg_frame_stats_if.sv
// avg_frame_stats_if
// Bundles the sample input, the report handshake and the frame statistics
// of avg_frame_stats into one interface.
// The "slave" modport is the view of the statistics block.
// The "master" modport is the view of whatever feeds it samples and consumes its reports.
// Optional feature macro: AVG_STATS_DROP_CNT_EN adds the drop_cnt signal.
interface avg_frame_stats_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  min_val;
    logic [7:0]  max_val;
    logic [15:0] sum_val;
    logic [7:0]  frame_no;
`ifdef AVG_STATS_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output min_val,
        output max_val,
        output sum_val,
        output frame_no
`ifdef AVG_STATS_DROP_CNT_EN
        ,
        output drop_cnt
`endif
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  min_val,
        input  max_val,
        input  sum_val,
        input  frame_no
`ifdef AVG_STATS_DROP_CNT_EN
        ,
        input  drop_cnt
`endif
    );

endinterface

// File: rtl/avg_frame_stats.sv
// avg_frame_stats
// Collects FRAME_LEN averaged samples per frame and tracks min, max and sum.
// FRAME_LEN has a legal range of 2..256.
// Once the frame is complete, it presents a report that is held until the consumer
// completes a valid/ready handshake.
// Samples that arrive while a report is pending are dropped.
// The report registers are separate from the running accumulators, so
// min_val/max_val/sum_val keep showing the last report while the next frame is
// being collected.
// Optional feature macro: AVG_STATS_DROP_CNT_EN compiles in an 8-bit saturating
// counter of samples dropped while a report is pending.
module avg_frame_stats #(
    parameter int FRAME_LEN = 120
) (
    input  logic           clk,
    input  logic           reset,
    avg_frame_stats_if.slave bus
);

    // The counter must be able to hold FRAME_LEN itself (256 needs 9 bits).
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;

    logic [7:0]       acc_min;
    logic [7:0]       acc_max;
    logic [15:0]      acc_sum;

    logic             rpt_valid;
    logic [7:0]       rpt_min;
    logic [7:0]       rpt_max;
    logic [15:0]      rpt_sum;
    logic [7:0]       rpt_frame;

    logic             accept;
    logic             first_sample;
    logic             last_sample;
    logic             handshake;
    logic [7:0]       next_min;
    logic [7:0]       next_max;
    logic [15:0]      next_sum;

    // Running statistics including the sample being accepted this cycle.
    // The first sample of a frame bypasses the compare so stale values never leak in.
    always_comb begin
        accept       = 1'b0;
        first_sample = 1'b0;
        last_sample  = 1'b0;
        handshake    = 1'b0;
        next_min     = acc_min;
        next_max     = acc_max;
        next_sum     = acc_sum;

        accept       = (state == COLLECT) && bus.in_valid;
        first_sample = (sample_cnt == '0);
        last_sample  = (sample_cnt == LAST_IDX);
        handshake    = (state == REPORT) && rpt_valid && bus.out_ready;

        if (first_sample) begin
            next_min = bus.in_data;
            next_max = bus.in_data;
            next_sum = {8'h00, bus.in_data};
        end else begin
            next_min = (bus.in_data < acc_min) ? bus.in_data : acc_min;
            next_max = (bus.in_data > acc_max) ? bus.in_data : acc_max;
            next_sum = acc_sum + {8'h00, bus.in_data};
        end
    end

    // Frame FSM: accumulate in COLLECT, latch and hold the report until handshake in REPORT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= COLLECT;
            sample_cnt <= '0;
            acc_min    <= 8'h00;
            acc_max    <= 8'h00;
            acc_sum    <= 16'h0000;
            rpt_valid  <= 1'b0;
            rpt_min    <= 8'h00;
            rpt_max    <= 8'h00;
            rpt_sum    <= 16'h0000;
            rpt_frame  <= 8'h00;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        acc_min    <= next_min;
                        acc_max    <= next_max;
                        acc_sum    <= next_sum;
                        if (last_sample) begin
                            rpt_min   <= next_min;
                            rpt_max   <= next_max;
                            rpt_sum   <= next_sum;
                            rpt_valid <= 1'b1;
                            state     <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (handshake) begin
                        rpt_valid  <= 1'b0;
                        rpt_frame  <= rpt_frame + 8'd1;
                        sample_cnt <= '0;
                        state      <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign bus.out_valid = rpt_valid;
    assign bus.min_val   = rpt_min;
    assign bus.max_val   = rpt_max;
    assign bus.sum_val   = rpt_sum;
    assign bus.frame_no  = rpt_frame;

`ifdef AVG_STATS_DROP_CNT_EN
    logic [7:0] drop_q;

    // Count samples discarded while a report is pending, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 8'h00;
        end else if ((state == REPORT) && bus.in_valid && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`endif

endmodule
